// File: rtl/mole_round_scheduler.sv
// Whack-a-mole round sequencer: tick prescaler, hole-picking LFSR, game/gap/up-time
// timing, hit/miss scoring. Every output is a register.
module mole_round_scheduler #(
  parameter int TICK_DIV      = 10000000,
  parameter int NUM_HOLES     = 4,
  parameter int GAP_TICKS     = 2,
  parameter int MOLE_ON_TICKS = 3,
  parameter int GAME_TICKS    = 60
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_HOLES-1:0] hit_btn,
  output logic                 tick,
  output logic [NUM_HOLES-1:0] mole,
  output logic [7:0]           score,
  output logic [7:0]           time_left,
  output logic                 busy,
  output logic                 game_over
);

  localparam int PRES_W = $clog2(TICK_DIV);
  localparam int HOLE_W = $clog2(NUM_HOLES);
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);
  localparam int UP_W   = $clog2(MOLE_ON_TICKS + 1);

  localparam logic [PRES_W-1:0] PRES_LAST = PRES_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic [UP_W-1:0]   UP_LAST   = UP_W'(MOLE_ON_TICKS - 1);
  localparam logic [7:0]        GAME_LEN  = 8'(GAME_TICKS);

  typedef enum logic [1:0] {IDLE, GAP, MOLE_UP, GAME_OVER} state_t;

  state_t               state, state_n;
  logic [PRES_W-1:0]    pres, pres_n;
  logic [7:0]           lfsr;
  logic [GAP_W-1:0]     gap_cnt, gap_n;
  logic [UP_W-1:0]      up_cnt, up_n;
  logic [HOLE_W-1:0]    hole, hole_n;
  logic [NUM_HOLES-1:0] mole_n;
  logic [7:0]           score_n, time_n;
  logic                 accept, mole_hit, mole_miss;

  assign accept    = start && (state == IDLE || state == GAME_OVER);
  assign mole_hit  = (state == MOLE_UP) && hit_btn[hole];
  assign mole_miss = (state == MOLE_UP) && (|hit_btn) && !hit_btn[hole];

  // Prescaler restarts on an accepted start so the first game tick is a full period away.
  assign pres_n = (accept || pres == PRES_LAST) ? '0 : pres + PRES_W'(1);

  always_comb begin
    state_n = state;
    score_n = score;
    time_n  = time_left;
    gap_n   = gap_cnt;
    up_n    = up_cnt;
    hole_n  = hole;
    mole_n  = mole;
    unique case (state)
      IDLE, GAME_OVER: begin
        if (start) begin
          state_n = GAP;
          score_n = 8'd0;
          time_n  = GAME_LEN;
          gap_n   = '0;
          mole_n  = '0;
        end
      end
      GAP: begin
        if (tick) begin
          time_n = time_left - 8'd1;
          if (time_left == 8'd1) begin
            state_n = GAME_OVER;
            mole_n  = '0;
          end else if (gap_cnt == GAP_LAST) begin
            state_n = MOLE_UP;
            hole_n  = lfsr[HOLE_W-1:0];
            mole_n  = '0;
            mole_n[lfsr[HOLE_W-1:0]] = 1'b1;
            up_n    = '0;
          end else begin
            gap_n = gap_cnt + GAP_W'(1);
          end
        end
      end
      MOLE_UP: begin
        // Scoring applies even when the same cycle ends the game or times the mole out.
        if (mole_hit) begin
          score_n = (score == 8'hFF) ? score : score + 8'd1;
        end else if (mole_miss) begin
          score_n = (score == 8'd0) ? score : score - 8'd1;
        end
        if (tick) begin
          time_n = time_left - 8'd1;
        end
        if (tick && time_left == 8'd1) begin
          state_n = GAME_OVER;
          mole_n  = '0;
        end else if (mole_hit) begin
          state_n = GAP;
          gap_n   = '0;
          mole_n  = '0;
        end else if (tick) begin
          if (up_cnt == UP_LAST) begin
            state_n = GAP;
            gap_n   = '0;
            mole_n  = '0;
          end else begin
            up_n = up_cnt + UP_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      pres      <= '0;
      lfsr      <= 8'hA5;
      gap_cnt   <= '0;
      up_cnt    <= '0;
      hole      <= '0;
      tick      <= 1'b0;
      mole      <= '0;
      score     <= 8'd0;
      time_left <= 8'd0;
      busy      <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      pres      <= pres_n;
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      gap_cnt   <= gap_n;
      up_cnt    <= up_n;
      hole      <= hole_n;
      tick      <= (pres_n == PRES_LAST);
      mole      <= mole_n;
      score     <= score_n;
      time_left <= time_n;
      busy      <= (state_n == GAP) || (state_n == MOLE_UP);
      game_over <= (state_n == GAME_OVER);
    end
  end

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Randomised and directed checks of mole_round_scheduler against a cycle-level
// game model kept in the bench.
module tb_mole_round_scheduler;

  localparam int TD = 4, NH = 4, GAPT = 2, MON = 3, GT = 20;
  localparam int P_IDLE = 0, P_GAP = 1, P_UP = 2, P_OVER = 3;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0;
  logic [NH-1:0] hit_btn = '0;
  logic tick, busy, game_over;
  logic [NH-1:0] mole;
  logic [7:0] score, time_left;

  int total = 0, bad = 0;

  int m_pres, m_phase, m_score, m_time, m_gap, m_up, m_hole;
  logic m_tick;
  logic [7:0] m_lfsr;
  logic [NH-1:0] m_mole;

  logic [22:0] obs_vec, exp_vec;
  assign obs_vec = {tick, mole, score, time_left, busy, game_over};
  assign exp_vec = {m_tick, m_mole, 8'(m_score), 8'(m_time),
                    (m_phase == P_GAP || m_phase == P_UP), (m_phase == P_OVER)};

  mole_round_scheduler #(
    .TICK_DIV(TD), .NUM_HOLES(NH), .GAP_TICKS(GAPT), .MOLE_ON_TICKS(MON), .GAME_TICKS(GT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .hit_btn(hit_btn),
    .tick(tick), .mole(mole), .score(score), .time_left(time_left),
    .busy(busy), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Game rules as a per-cycle event model: what the next clock edge should produce.
  task automatic model(input logic r, input logic s, input logic [NH-1:0] h);
    bit go, hitm, missm;
    if (r) begin
      m_pres = 0; m_tick = 0; m_lfsr = 8'hA5; m_phase = P_IDLE;
      m_score = 0; m_time = 0; m_gap = 0; m_up = 0; m_hole = 0; m_mole = '0;
      return;
    end
    go = s && (m_phase == P_IDLE || m_phase == P_OVER);
    if (go) begin
      m_phase = P_GAP; m_score = 0; m_time = GT; m_gap = 0; m_mole = '0;
    end else if (m_phase == P_GAP || m_phase == P_UP) begin
      hitm  = (m_phase == P_UP) && h[m_hole];
      missm = (m_phase == P_UP) && (h != 0) && !h[m_hole];
      if (hitm && m_score < 255) m_score++;
      if (missm && m_score > 0) m_score--;
      if (m_tick) m_time--;
      if (m_tick && m_time == 0) begin
        m_phase = P_OVER; m_mole = '0;
      end else if (hitm) begin
        m_phase = P_GAP; m_gap = 0; m_mole = '0;
      end else if (m_tick && m_phase == P_GAP) begin
        m_gap++;
        if (m_gap == GAPT) begin
          m_phase = P_UP; m_hole = int'(m_lfsr[1:0]); m_mole = NH'(1 << m_hole); m_up = 0;
        end
      end else if (m_tick && m_phase == P_UP) begin
        m_up++;
        if (m_up == MON) begin
          m_phase = P_GAP; m_gap = 0; m_mole = '0;
        end
      end
    end
    m_pres = go ? 0 : (m_pres + 1) % TD;
    m_tick = (m_pres == TD - 1);
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [NH-1:0] h);
    reset = r; start = s; hit_btn = h;
    model(r, s, h);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; hit_btn = '0;
  endtask

  task automatic new_game();
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, '0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, '0);
      total++;
      if (obs_vec !== 23'd0) begin
        bad++; $display("[TB] FAIL reset_outputs got=%h want=%h", obs_vec, 23'd0);
      end
    end
  endtask

  task automatic test_idle();
    int ticks = 0;
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b0, 1'b0, 4'hF);
      if (tick) ticks++;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL idle_c%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
    total++;
    if (ticks !== 12) begin
      bad++; $display("[TB] FAIL idle_tick_count got=%0d want=12", ticks);
    end
  endtask

  task automatic test_start();
    int first_tick = -1, mole_at = -1;
    applyStimulus(1'b0, 1'b1, '0);
    total++;
    if (busy !== 1'b1 || time_left !== 8'd20) begin
      bad++; $display("[TB] FAIL start_busy got=%b/%0d want=1/20", busy, time_left);
    end
    for (int i = 1; i <= 12 && mole_at < 0; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (tick && first_tick < 0) first_tick = i;
      if (mole != 0) mole_at = i;
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL start_c%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
    total++;
    if (first_tick !== 3 || mole_at !== 8 || !$onehot(mole)) begin
      bad++; $display("[TB] FAIL start_timing got=tick@%0d mole@%0d %b want=tick@3 mole@8 onehot",
                      first_tick, mole_at, mole);
    end
  endtask

  task automatic test_hit_miss();
    logic [NH-1:0] wrong;
    applyStimulus(1'b0, 1'b0, m_mole);
    total++;
    if (score !== 8'd1 || mole !== '0) begin
      bad++; $display("[TB] FAIL hit_score got=%0d/%b want=1/0000", score, mole);
    end
    for (int i = 0; i < 30 && m_mole == 0; i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL hit_gap_c%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
    wrong = {m_mole[NH-2:0], m_mole[NH-1]};
    applyStimulus(1'b0, 1'b0, wrong);
    total++;
    if (score !== 8'd0 || obs_vec !== exp_vec) begin
      bad++; $display("[TB] FAIL miss_once got=%h want=%h", obs_vec, exp_vec);
    end
    applyStimulus(1'b0, 1'b0, wrong);
    total++;
    if (score !== 8'd0) begin
      bad++; $display("[TB] FAIL miss_floor got=%0d want=0", score);
    end
  endtask

  task automatic test_timeout();
    int up_ticks = 0;
    new_game();
    for (int i = 0; i < 30 && m_mole == 0; i++) applyStimulus(1'b0, 1'b0, '0);
    for (int i = 0; i < 30 && m_mole != 0; i++) begin
      if (mole != 0 && tick) up_ticks++;
      applyStimulus(1'b0, 1'b0, '0);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL timeout_c%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
    total++;
    if (up_ticks !== MON || score !== 8'd0) begin
      bad++; $display("[TB] FAIL timeout_ticks got=%0d/%0d want=%0d/0", up_ticks, score, MON);
    end
    for (int i = 0; i < 60 && !(m_mole != 0 && m_tick && m_up == MON - 1); i++)
      applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, m_mole);
    total++;
    if (score !== 8'd1 || mole !== '0) begin
      bad++; $display("[TB] FAIL hit_on_timeout got=%0d/%b want=1/0000", score, mole);
    end
  endtask

  task automatic test_game_over();
    new_game();
    for (int i = 0; i < 200 && !(m_tick && m_time == 1); i++) begin
      applyStimulus(1'b0, 1'b0, '0);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL game_c%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
    total++;
    if (mole === '0 || time_left !== 8'd1) begin
      bad++; $display("[TB] FAIL final_tick_setup got=%b/%0d want=mole/1", mole, time_left);
    end
    applyStimulus(1'b0, 1'b0, m_mole);
    total++;
    if ({game_over, busy, mole, time_left, score} !== {1'b1, 1'b0, 4'h0, 8'd0, 8'd1}) begin
      bad++; $display("[TB] FAIL final_hit got=go%b busy%b m%b t%0d s%0d want=go1 busy0 m0000 t0 s1",
                      game_over, busy, mole, time_left, score);
    end
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 4'hF);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL over_hold_c%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
    applyStimulus(1'b0, 1'b1, '0);
    total++;
    if (score !== 8'd0 || time_left !== 8'd20 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL restart got=%0d/%0d/%b want=0/20/1", score, time_left, busy);
    end
  endtask

  task automatic test_reset_mid_game();
    logic [7:0] t_before;
    new_game();
    for (int i = 0; i < 400 && !(m_mole != 0 && m_score == 5); i++) begin
      if (m_phase == P_OVER) applyStimulus(1'b0, 1'b1, '0);
      else applyStimulus(1'b0, 1'b0, (m_mole != 0) ? m_mole : 4'h0);
    end
    total++;
    if (score !== 8'd5 || mole === '0) begin
      bad++; $display("[TB] FAIL reach_score5 got=%0d/%b want=5/mole", score, mole);
    end
    applyStimulus(1'b1, 1'b0, '0);
    total++;
    if (obs_vec !== 23'd0) begin
      bad++; $display("[TB] FAIL mid_reset got=%h want=%h", obs_vec, 23'd0);
    end
    new_game();
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, '0);
    t_before = time_left;
    applyStimulus(1'b0, 1'b1, '0);
    total++;
    if (time_left === 8'd20 || time_left > t_before || obs_vec !== exp_vec) begin
      bad++; $display("[TB] FAIL busy_start got=%h want=%h", obs_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    logic r, s;
    logic [NH-1:0] h;
    new_game();
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 699) == 0);
      s = ($urandom_range(0, 49) == 0);
      h = '0;
      if ($urandom_range(0, 7) == 0) h = NH'($urandom_range(1, 15));
      else if (m_mole != 0 && $urandom_range(0, 3) == 0) h = m_mole;
      applyStimulus(r, s, h);
      total++;
      if (obs_vec !== exp_vec) begin
        bad++; $display("[TB] FAIL random_c%0d got=%h want=%h", i, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_start();
    test_hit_miss();
    test_timeout();
    test_game_over();
    test_reset_mid_game();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
